// File: rtl/reg_arb_pkg.sv
// Shared types for the register arbiter: FSM encoding, default data width
// and the round-robin winner pick.
package reg_arb_pkg;

    localparam int DEF_WIDTH = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Scan upward from ptr, wrapping at n; the first set request wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] ptr,
                                           input int         n);
        logic [1:0] win;
        logic       found;
        int         idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = int'(ptr) + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && req[idx[1:0]]) begin
                win   = idx[1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/reg_arb_reg.sv
// Enable register with synchronous active-high clear; loads d on en.
// One-cycle latency, no backpressure.
module reg_arb_reg
    import reg_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_arbiter.sv
// Round-robin arbiter for writes into one shared register: IDLE -> WRITE -> DONE.
// Grant one cycle after req is seen, q updates on WRITE exit; losers simply hold req.
module reg_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       q,
    output logic [1:0]             owner,
    output logic                   busy
);

    state_t             st, st_nxt;
    logic [1:0]         id, ptr, win, ptr_nxt;
    logic [3:0]         req_pad;
    logic               hit, wr, dn, rst;
    logic [WIDTH-1:0]   wdat;

    always_comb begin
        req_pad             = '0;
        req_pad[N_REQ-1:0]  = req;
    end

    assign hit     = |req;
    assign win     = rr_pick(req_pad, ptr, N_REQ);
    assign ptr_nxt = (id == 2'(N_REQ - 1)) ? 2'd0 : id + 2'd1;

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:    if (hit) st_nxt = WRITE;
            WRITE:   st_nxt = DONE;
            DONE:    st_nxt = IDLE;
            default: st_nxt = IDLE;
        endcase
    end

    // Outputs are masked by reset so an in-flight operation goes quiet immediately.
    assign wr   = reset && (st == WRITE);
    assign dn   = reset && (st == DONE);
    assign busy = reset && (st != IDLE);

    always_comb begin
        gnt  = '0;
        done = '0;
        wdat = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i]  = wr && (id == 2'(i));
            done[i] = dn && (id == 2'(i));
            if (id == 2'(i)) wdat = data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            st    <= IDLE;
            ptr   <= '0;
            id    <= '0;
            owner <= '0;
        end else begin
            st <= st_nxt;
            if (st == IDLE && hit) id    <= win;
            if (st == WRITE)       owner <= id;
            if (st == DONE)        ptr   <= ptr_nxt;
        end
    end

    // The register clears on an active-high input.
    assign rst = ~reset;

    reg_arb_reg #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk (clk),
        .rst (rst),
        .en  (wr),
        .d   (wdat),
        .q   (q)
    );

endmodule

// File: tb/tb_reg_arbiter.sv
// Directed bench for reg_arbiter: reset, single write, round-robin order,
// mid-write deassert, repeated single requester and reset abort.
module tb_reg_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [6:0]  d0, d1, d2;
    logic [20:0] data;
    logic [2:0]  gnt, done;
    logic [6:0]  q;
    logic [1:0]  owner;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    assign data = {d2, d1, d0};

    reg_arbiter #(.N_REQ(3), .WIDTH(7)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .data  (data),
        .gnt   (gnt),
        .done  (done),
        .q     (q),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] eg, input logic [2:0] ed,
                           input logic [6:0] eq, input logic eb);
        chk({tag, ".gnt"},  32'(gnt),  32'(eg));
        chk({tag, ".done"}, 32'(done), 32'(ed));
        chk({tag, ".q"},    32'(q),    32'(eq));
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
    endtask

    logic [1:0] exp_id [4];
    logic [6:0] exp_q  [4];

    initial begin
        reset = 1'b0;
        req   = 3'b111;
        d0 = 7'h01; d1 = 7'h2A; d2 = 7'h04;

        // Reset held with all requests active
        tick(); chk_all("rst0", 3'b000, 3'b000, 7'h00, 1'b0);
        tick(); chk_all("rst1", 3'b000, 3'b000, 7'h00, 1'b0);
        chk("rst.owner", 32'(owner), 32'd0);

        // Single requester 1 writes 2A
        reset = 1'b1;
        req   = 3'b010;
        tick(); chk_all("one.wr", 3'b010, 3'b000, 7'h00, 1'b1);
        req = 3'b000;
        tick(); chk_all("one.dn", 3'b000, 3'b010, 7'h2A, 1'b1);
        chk("one.owner", 32'(owner), 32'd1);
        tick(); chk_all("one.idle", 3'b000, 3'b000, 7'h2A, 1'b0);

        // Re-reset so the pointer is back at 0, then all three request together
        reset = 1'b0;
        tick();
        chk("rr.rst.q", 32'(q), 32'd0);
        reset = 1'b1;
        req   = 3'b111;
        d0 = 7'h01; d1 = 7'h02; d2 = 7'h04;
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd0};
        exp_q  = '{7'h01, 7'h02, 7'h04, 7'h01};
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(3'b001 << exp_id[k]));
            chk($sformatf("rr%0d.dn0", k), 32'(done), 32'd0);
            tick();
            chk($sformatf("rr%0d.q", k),     32'(q),     32'(exp_q[k]));
            chk($sformatf("rr%0d.done", k),  32'(done),  32'(3'b001 << exp_id[k]));
            chk($sformatf("rr%0d.owner", k), 32'(owner), 32'(exp_id[k]));
            chk($sformatf("rr%0d.g0", k),    32'(gnt),   32'd0);
            tick();
            chk($sformatf("rr%0d.idle", k),  32'(busy),  32'd0);
            if (k == 3) req = 3'b000;
        end

        // Requester 2 drops req during its WRITE; write still completes
        req = 3'b100;
        d2  = 7'h55;
        tick(); chk_all("drop.wr", 3'b100, 3'b000, 7'h01, 1'b1);
        req = 3'b000;
        tick(); chk_all("drop.dn", 3'b000, 3'b100, 7'h55, 1'b1);
        chk("drop.owner", 32'(owner), 32'd2);
        tick(); chk_all("drop.idle", 3'b000, 3'b000, 7'h55, 1'b0);

        // Requester 1 holds req: regranted every third cycle
        req = 3'b010;
        d1  = 7'h3C;
        for (int k = 0; k < 2; k++) begin
            tick(); chk_all($sformatf("hold%0d.wr", k), 3'b010, 3'b000, (k == 0) ? 7'h55 : 7'h3C, 1'b1);
            tick(); chk_all($sformatf("hold%0d.dn", k), 3'b000, 3'b010, 7'h3C, 1'b1);
            tick(); chk_all($sformatf("hold%0d.id", k), 3'b000, 3'b000, 7'h3C, 1'b0);
            if (k == 1) req = 3'b000;
        end

        // Pointer now sits at 2; requester 2 is aborted by reset mid-WRITE
        req = 3'b100;
        tick(); chk_all("abort.wr", 3'b100, 3'b000, 7'h3C, 1'b1);
        reset = 1'b0;
        #1;
        chk("abort.gnt.comb",  32'(gnt),  32'd0);
        chk("abort.busy.comb", 32'(busy), 32'd0);
        tick(); chk_all("abort.edge", 3'b000, 3'b000, 7'h00, 1'b0);
        chk("abort.owner", 32'(owner), 32'd0);

        // After reset the scan starts from requester 0 again
        reset = 1'b1;
        req   = 3'b111;
        tick(); chk_all("post.wr", 3'b001, 3'b000, 7'h00, 1'b1);
        req = 3'b000;
        tick(); chk_all("post.dn", 3'b000, 3'b001, 7'h01, 1'b1);
        tick(); chk_all("post.idle", 3'b000, 3'b000, 7'h01, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
